// File: rtl/demosaic_pkg.sv
// Shared types for the parametrised Bayer demosaic engine: FSM states, CFA
// layouts, plane colours and the phase-to-colour mapping.
package demosaic_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_LOAD,
      S_INTERP,
      S_SAVE,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      CFA_RGGB = 2'd0,
      CFA_GRBG = 2'd1,
      CFA_GBRG = 2'd2,
      CFA_BGGR = 2'd3
   } cfa_t;

   typedef enum logic [1:0] {
      COL_R = 2'd0,
      COL_G = 2'd1,
      COL_B = 2'd2
   } colour_t;

   // Phase {row parity, col parity} after folding in the CFA pattern bits.
   function automatic colour_t phase_colour(input logic [1:0] ph);
      case (ph)
         2'b00:   return COL_R;
         2'b11:   return COL_B;
         default: return COL_G;
      endcase
   endfunction

endpackage

// File: rtl/demosaic_nbr_addr.sv
// Mirrored-border neighbour address generator. Works relative to the linear
// index so no multiplier is needed; mirroring swaps the step direction.
module demosaic_nbr_addr #(
   parameter int DIM_W  = 11,
   parameter int ADDR_W = 19
) (
   input  logic [DIM_W-1:0]  row,
   input  logic [DIM_W-1:0]  col,
   input  logic [DIM_W-1:0]  width,
   input  logic [DIM_W-1:0]  height,
   input  logic [ADDR_W-1:0] idx,
   input  logic [1:0]        k,
   input  logic              rb_site,
   output logic [ADDR_W-1:0] addr_x,
   output logic [ADDR_W-1:0] addr_y
);

   logic [ADDR_W-1:0] wl;
   logic              at_top, at_bot, at_left, at_right;
   logic [ADDR_W-1:0] up, down, left, right, ul, ur, dl, dr;

   assign wl       = ADDR_W'(width);
   assign at_top   = (row == '0);
   assign at_bot   = (row == height - DIM_W'(1));
   assign at_left  = (col == '0);
   assign at_right = (col == width - DIM_W'(1));

   assign up    = at_top ? idx + wl : idx - wl;
   assign down  = at_bot ? idx - wl : idx + wl;
   assign left  = at_left  ? idx + ADDR_W'(1) : idx - ADDR_W'(1);
   assign right = at_right ? idx - ADDR_W'(1) : idx + ADDR_W'(1);
   assign ul    = at_left  ? up + ADDR_W'(1)   : up - ADDR_W'(1);
   assign ur    = at_right ? up - ADDR_W'(1)   : up + ADDR_W'(1);
   assign dl    = at_left  ? down + ADDR_W'(1) : down - ADDR_W'(1);
   assign dr    = at_right ? down - ADDR_W'(1) : down + ADDR_W'(1);

   // G site: x = horizontal pair, y = vertical pair. R/B site: x = G cross, y = diagonals.
   always_comb begin
      addr_x = left;
      addr_y = up;
      if (!rb_site) begin
         addr_x = k[0] ? right : left;
         addr_y = k[0] ? down  : up;
      end else begin
         case (k)
            2'd0:    begin addr_x = up;    addr_y = ul; end
            2'd1:    begin addr_x = left;  addr_y = ur; end
            2'd2:    begin addr_x = right; addr_y = dl; end
            default: begin addr_x = down;  addr_y = dr; end
         endcase
      end
   end

endmodule

// File: rtl/bayer_demosaic_param.sv
// Bilinear Bayer demosaic: loads a raw mosaic into R/G/B plane memories, then
// fills each pixel's two missing channels from mirrored neighbours.
module bayer_demosaic_param
   import demosaic_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DIM_W  = 11,
   parameter int ADDR_W = 19,
   parameter int ROUND  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_en,
   input  logic [DIM_W-1:0]  width,
   input  logic [DIM_W-1:0]  height,
   input  logic [1:0]        pattern,
   output logic [ADDR_W-1:0] img_addr,
   input  logic [DATA_W-1:0] data_in,
   output logic              wr_r,
   output logic              wr_g,
   output logic              wr_b,
   output logic [ADDR_W-1:0] addr_r,
   output logic [ADDR_W-1:0] addr_g,
   output logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] wdata_r,
   output logic [DATA_W-1:0] wdata_g,
   output logic [DATA_W-1:0] wdata_b,
   input  logic [DATA_W-1:0] rdata_r,
   input  logic [DATA_W-1:0] rdata_g,
   input  logic [DATA_W-1:0] rdata_b,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int PROD_W = (2 * DIM_W > ADDR_W + 1) ? 2 * DIM_W : ADDR_W + 1;
   localparam int ACC_W  = DATA_W + 2;

   state_t            state;
   cfa_t              pat;
   logic [DIM_W-1:0]  w, h, row, col, next_row, next_col;
   logic [ADDR_W-1:0] idx, addr_x, addr_y;
   logic [1:0]        k, ph, pat_bits;
   logic [ACC_W-1:0]  acc_x, acc_y, bias, sum_x, sum_y;
   logic [DATA_W-1:0] rdata_x, rdata_y, avg_x, avg_y;
   logic [PROD_W-1:0] area;
   colour_t           native, x_col, y_col;
   logic              rb_site, last_k, last_pix, illegal;

   assign pat_bits = pat;
   assign ph       = {row[0] ^ pat_bits[1], col[0] ^ pat_bits[0]};
   assign native   = phase_colour(ph);
   assign rb_site  = (native != COL_G);
   assign last_k   = rb_site ? (k == 2'd3) : (k == 2'd1);
   assign last_pix = (row == h - DIM_W'(1)) && (col == w - DIM_W'(1));
   assign area     = PROD_W'(w) * PROD_W'(h);
   assign illegal  = (w < DIM_W'(2)) || (h < DIM_W'(2)) || (area > (PROD_W'(1) << ADDR_W));

   // x/y are the two missing colours of the current pixel, in neighbour-read order.
   always_comb begin
      x_col = COL_G;
      y_col = (native == COL_R) ? COL_B : COL_R;
      if (!rb_site) begin
         x_col = (ph == 2'b01) ? COL_R : COL_B;
         y_col = (ph == 2'b01) ? COL_B : COL_R;
      end
   end

   always_comb begin
      next_col = col + DIM_W'(1);
      next_row = row;
      if (col == w - DIM_W'(1)) begin
         next_col = '0;
         next_row = row + DIM_W'(1);
      end
   end

   always_comb begin
      case (x_col)
         COL_R:   rdata_x = rdata_r;
         COL_G:   rdata_x = rdata_g;
         default: rdata_x = rdata_b;
      endcase
      case (y_col)
         COL_R:   rdata_y = rdata_r;
         COL_G:   rdata_y = rdata_g;
         default: rdata_y = rdata_b;
      endcase
   end

   // Divide by 2 or 4; the bias turns truncation into round-half-up.
   assign bias  = (ROUND != 0) ? (rb_site ? ACC_W'(2) : ACC_W'(1)) : '0;
   assign sum_x = acc_x + bias;
   assign sum_y = acc_y + bias;
   assign avg_x = rb_site ? sum_x[ACC_W-1:2] : sum_x[ACC_W-2:1];
   assign avg_y = rb_site ? sum_y[ACC_W-1:2] : sum_y[ACC_W-2:1];

   demosaic_nbr_addr #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_nbr (
      .row     (row),
      .col     (col),
      .width   (w),
      .height  (h),
      .idx     (idx),
      .k       (k),
      .rb_site (rb_site),
      .addr_x  (addr_x),
      .addr_y  (addr_y)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         pat   <= CFA_RGGB;
         w     <= '0;
         h     <= '0;
         row   <= '0;
         col   <= '0;
         idx   <= '0;
         k     <= '0;
         acc_x <= '0;
         acc_y <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_en) begin
                  w     <= width;
                  h     <= height;
                  pat   <= cfa_t'(pattern);
                  busy  <= 1'b1;
                  err   <= 1'b0;
                  state <= S_CHECK;
               end
            end
            S_CHECK: begin
               row <= '0;
               col <= '0;
               idx <= '0;
               if (illegal) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (last_pix) begin
                  row   <= '0;
                  col   <= '0;
                  idx   <= '0;
                  k     <= '0;
                  state <= S_INTERP;
               end else begin
                  row <= next_row;
                  col <= next_col;
                  idx <= idx + ADDR_W'(1);
               end
            end
            S_INTERP: begin
               acc_x <= acc_x + {2'b00, rdata_x};
               acc_y <= acc_y + {2'b00, rdata_y};
               k     <= k + 2'd1;
               if (last_k) state <= S_SAVE;
            end
            S_SAVE: begin
               acc_x <= '0;
               acc_y <= '0;
               k     <= '0;
               if (last_pix) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  row   <= next_row;
                  col   <= next_col;
                  idx   <= idx + ADDR_W'(1);
                  state <= S_INTERP;
               end
            end
            default: begin
               busy  <= 1'b0;
               err   <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Memory-side outputs are decoded from the registered state and counters.
   always_comb begin
      img_addr = '0;
      wr_r     = 1'b0;
      wr_g     = 1'b0;
      wr_b     = 1'b0;
      addr_r   = '0;
      addr_g   = '0;
      addr_b   = '0;
      wdata_r  = '0;
      wdata_g  = '0;
      wdata_b  = '0;
      case (state)
         S_LOAD: begin
            img_addr = idx;
            addr_r   = idx;
            addr_g   = idx;
            addr_b   = idx;
            wdata_r  = data_in;
            wdata_g  = data_in;
            wdata_b  = data_in;
            wr_r     = (native == COL_R);
            wr_g     = (native == COL_G);
            wr_b     = (native == COL_B);
         end
         S_INTERP: begin
            if (x_col == COL_R) addr_r = addr_x;
            else if (y_col == COL_R) addr_r = addr_y;
            if (x_col == COL_G) addr_g = addr_x;
            else if (y_col == COL_G) addr_g = addr_y;
            if (x_col == COL_B) addr_b = addr_x;
            else if (y_col == COL_B) addr_b = addr_y;
         end
         S_SAVE: begin
            if (native != COL_R) begin
               wr_r    = 1'b1;
               addr_r  = idx;
               wdata_r = (x_col == COL_R) ? avg_x : avg_y;
            end
            if (native != COL_G) begin
               wr_g    = 1'b1;
               addr_g  = idx;
               wdata_g = (x_col == COL_G) ? avg_x : avg_y;
            end
            if (native != COL_B) begin
               wr_b    = 1'b1;
               addr_b  = idx;
               wdata_b = (x_col == COL_B) ? avg_x : avg_y;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bayer_demosaic_param.sv
// Bench for bayer_demosaic_param: truncating and rounding instances side by
// side, memories modelled here, results against a neighbour-averaging model.
module tb_bayer_demosaic_param;

   localparam int AW   = 8;
   localparam int NPIX = 1 << AW;

   typedef struct {
      int w;
      int h;
      int pat;
      int fill;
      bit exp_err;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_en = 1'b0;
   logic [10:0]   width = '0;
   logic [10:0]   height = '0;
   logic [1:0]    pattern = '0;
   logic [AW-1:0] img_addr [2];
   logic [7:0]    data_in [2];
   logic          wr [2][3];
   logic [AW-1:0] addr [2][3];
   logic [7:0]    wdata [2][3];
   logic [7:0]    rdata [2][3];
   logic          busy [2];
   logic          done [2];
   logic          err [2];

   logic [7:0] img [NPIX];
   logic [7:0] pl [2][3][NPIX];
   int         expv [2][3][NPIX];
   logic       scrub = 1'b0;
   int         strobes = 0;
   int         vectors = 0;
   int         miscompares = 0;
   string      tiles [4] = '{"RGGB", "GRBG", "GBRG", "BGGR"};

   always #5 clk = ~clk;

   for (genvar d = 0; d < 2; d++) begin : g_dut
      assign data_in[d] = img[img_addr[d]];
      for (genvar c = 0; c < 3; c++) begin : g_rd
         assign rdata[d][c] = pl[d][c][addr[d][c]];
      end
      bayer_demosaic_param #(.DATA_W(8), .DIM_W(11), .ADDR_W(AW), .ROUND(d)) dut (
         .clk(clk), .reset(reset), .in_en(in_en),
         .width(width), .height(height), .pattern(pattern),
         .img_addr(img_addr[d]), .data_in(data_in[d]),
         .wr_r(wr[d][0]), .wr_g(wr[d][1]), .wr_b(wr[d][2]),
         .addr_r(addr[d][0]), .addr_g(addr[d][1]), .addr_b(addr[d][2]),
         .wdata_r(wdata[d][0]), .wdata_g(wdata[d][1]), .wdata_b(wdata[d][2]),
         .rdata_r(rdata[d][0]), .rdata_g(rdata[d][1]), .rdata_b(rdata[d][2]),
         .busy(busy[d]), .done(done[d]), .err(err[d])
      );
   end

   // Plane memories; scrub fills them with junk so missing writes show up.
   always @(posedge clk) begin
      bit any;
      any = 1'b0;
      if (scrub) begin
         strobes <= 0;
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++)
               for (int i = 0; i < NPIX; i++)
                  pl[d][c][i] <= 8'($urandom);
      end else begin
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++)
               if (wr[d][c]) begin
                  pl[d][c][addr[d][c]] <= wdata[d][c];
                  any = 1'b1;
               end
         if (any) strobes <= strobes + 1;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic bit outputsQuiet();
      for (int d = 0; d < 2; d++) begin
         if (busy[d] || done[d] || err[d] || img_addr[d] != '0) return 1'b0;
         for (int c = 0; c < 3; c++)
            if (wr[d][c] || addr[d][c] != '0 || wdata[d][c] != '0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int mir(input int x, input int n);
      if (x < 0) return 1;
      if (x >= n) return n - 2;
      return x;
   endfunction

   // 0 = R, 1 = G, 2 = B, read off the 2x2 CFA tile.
   function automatic int colourOf(input int r, input int c, input int pat);
      string t;
      t = tiles[pat];
      case (t[(r % 2) * 2 + (c % 2)])
         "R":     return 0;
         "G":     return 1;
         default: return 2;
      endcase
   endfunction

   function automatic int costUpTo(input int w, input int h, input int pat, input int npix);
      int total;
      total = 0;
      for (int p = 0; p < npix && p < w * h; p++)
         total += (colourOf(p / w, p % w, pat) == 1) ? 3 : 5;
      return total;
   endfunction

   // Average the nearest mirrored neighbours of the wanted colour: edge-adjacent first, else diagonal.
   task automatic buildModel(input int w, input int h, input int pat);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            int p, nat;
            p   = r * w + c;
            nat = colourOf(r, c, pat);
            for (int col = 0; col < 3; col++) begin
               int sum, n;
               sum = 0;
               n   = 0;
               if (col == nat) begin
                  expv[0][col][p] = img[p];
                  expv[1][col][p] = img[p];
                  continue;
               end
               for (int q = 0; q < 4; q++) begin
                  int rr, cc;
                  rr = mir(r + ((q == 0) ? -1 : (q == 1) ? 1 : 0), h);
                  cc = mir(c + ((q == 2) ? -1 : (q == 3) ? 1 : 0), w);
                  if (colourOf(rr, cc, pat) == col) begin
                     sum += img[rr * w + cc];
                     n++;
                  end
               end
               if (n == 0)
                  for (int q = 0; q < 4; q++) begin
                     int rr, cc;
                     rr = mir(r + ((q < 2) ? -1 : 1), h);
                     cc = mir(c + ((q % 2 == 0) ? -1 : 1), w);
                     sum += img[rr * w + cc];
                     n++;
                  end
               expv[0][col][p] = sum / n;
               expv[1][col][p] = (sum + n / 2) / n;
            end
         end
   endtask

   task automatic startFrame(input int w, input int h, input int pat);
      @(negedge clk);
      scrub = 1'b1;
      @(negedge clk);
      scrub   = 1'b0;
      width   = 11'(w);
      height  = 11'(h);
      pattern = 2'(pat);
      in_en   = 1'b1;
      @(negedge clk);
      in_en = 1'b0;
   endtask

   // n counts negedges from the sampling edge: done in cycle n.
   task automatic applyStimulus(input int w, input int h, input int pat, output int n, output bit ok);
      startFrame(w, h, pat);
      n = 1;
      checkOutput("busy_after_start", int'(busy[0]), 1);
      while (!done[0] && n < 5000) begin
         @(negedge clk);
         n++;
      end
      ok = done[0];
      checkOutput("done_seen", int'(ok), 1);
      if (!ok) begin
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
      end
   endtask

   task automatic checkFrame(input int w, input int h, input int pat, input bit exp_err, input int n);
      int lat;
      lat = exp_err ? 2 : 2 + w * h + costUpTo(w, h, pat, w * h);
      checkOutput($sformatf("latency %0dx%0d p%0d", w, h, pat), n, lat);
      checkOutput("err_with_done", int'(err[0]), int'(exp_err));
      checkOutput("err_with_done_round", int'(err[1]), int'(exp_err));
      checkOutput("done_round", int'(done[1]), 1);
      @(negedge clk);
      checkOutput("done_one_cycle", int'(done[0]), 0);
      checkOutput("busy_cleared", int'(busy[0]), 0);
      checkOutput("idle_quiet", int'(outputsQuiet()), 1);
      checkOutput("strobe_cycles", strobes, exp_err ? 0 : 2 * w * h);
      if (!exp_err)
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++)
               for (int p = 0; p < w * h; p++)
                  checkOutput($sformatf("plane round%0d c%0d p%0d", d, c, p), int'(pl[d][c][p]), expv[d][c][p]);
   endtask

   task automatic runVector(input vec_t v);
      int n;
      bit ok;
      for (int i = 0; i < NPIX; i++) img[i] = (v.fill < 0) ? 8'($urandom) : 8'(v.fill);
      if (!v.exp_err) buildModel(v.w, v.h, v.pat);
      applyStimulus(v.w, v.h, v.pat, n, ok);
      if (ok) checkFrame(v.w, v.h, v.pat, v.exp_err, n);
   endtask

   initial begin
      vec_t tbl [18];
      int   n, target;
      bit   ok;

      tbl[0]  = '{4, 4, 1, 100, 1'b0};
      tbl[1]  = '{1, 8, 0, 0, 1'b1};
      tbl[2]  = '{8, 1, 2, 0, 1'b1};
      tbl[3]  = '{0, 5, 1, 0, 1'b1};
      tbl[4]  = '{17, 16, 3, 0, 1'b1};
      tbl[5]  = '{16, 16, 1, -1, 1'b0};
      tbl[6]  = '{2, 2, 3, -1, 1'b0};
      tbl[7]  = '{5, 3, 2, -1, 1'b0};
      tbl[8]  = '{2, 7, 0, -1, 1'b0};
      for (int p = 0; p < 4; p++) begin
         tbl[9 + p]  = '{8, 6, p, -1, 1'b0};
         tbl[13 + p] = '{8, 6, p, 255, 1'b0};
      end
      tbl[17] = '{3, 5, 1, -1, 1'b0};

      repeat (3) @(negedge clk);
      checkOutput("reset_quiet", int'(outputsQuiet()), 1);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_after_reset", int'(outputsQuiet()), 1);

      for (int i = 0; i < 18; i++) runVector(tbl[i]);

      // 2x2 RGGB with known values: mirrored corners.
      for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
      img[0] = 8'd40; img[1] = 8'd10; img[2] = 8'd30; img[3] = 8'd80;
      buildModel(2, 2, 0);
      applyStimulus(2, 2, 0, n, ok);
      if (ok) begin
         checkFrame(2, 2, 0, 1'b0, n);
         for (int d = 0; d < 2; d++) begin
            checkOutput("corner00_g", int'(pl[d][1][0]), 20);
            checkOutput("corner00_b", int'(pl[d][2][0]), 80);
            checkOutput("corner01_r", int'(pl[d][0][1]), 40);
            checkOutput("corner01_b", int'(pl[d][2][1]), 80);
         end
      end

      // 3x2 GRBG: G site (1,1) sees B neighbours 1 and 2.
      for (int i = 0; i < NPIX; i++) img[i] = 8'd50;
      img[3] = 8'd1; img[5] = 8'd2;
      buildModel(3, 2, 1);
      applyStimulus(3, 2, 1, n, ok);
      if (ok) begin
         checkFrame(3, 2, 1, 1'b0, n);
         checkOutput("trunc_avg", int'(pl[0][2][4]), 1);
         checkOutput("round_avg", int'(pl[1][2][4]), 2);
      end

      // 6x4 abort during INTERP of pixel 10, then a clean rerun.
      for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
      buildModel(6, 4, 2);
      startFrame(6, 4, 2);
      n = 1;
      target = 3 + 24 + costUpTo(6, 4, 2, 10);
      while (n < target) begin
         @(negedge clk);
         n++;
      end
      checkOutput("busy_before_abort", int'(busy[0]), 1);
      reset = 1'b1;
      #1;
      checkOutput("abort_quiet", int'(outputsQuiet()), 1);
      @(negedge clk);
      checkOutput("abort_held_quiet", int'(outputsQuiet()), 1);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_idle", int'(outputsQuiet()), 1);
      applyStimulus(6, 4, 2, n, ok);
      if (ok) checkFrame(6, 4, 2, 1'b0, n);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
